// File: rtl/intrpt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intrpt_ctrl_pkg
//   Shared definitions for the machine-mode interrupt sequencer.
//   - state_t      : sequencer state (IDLE / HANDLER), 2-bit encoding
//   - CSR_MIE_ADDR : CSR address that the MIE write request is muxed onto
//   - align_mtvec  : direct-mode trap vector (low two bits forced to zero)
// -----------------------------------------------------------------------------
package intrpt_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HANDLER = 2'd1
   } state_t;

   // mstatus holds MIE; the top-level CSR write mux targets this address.
   localparam logic [11:0] CSR_MIE_ADDR = 12'h300;

   // Only direct mode is supported, so the mode field of mtvec is discarded.
   function automatic logic [31:0] align_mtvec(input logic [31:0] mtvec);
      return {mtvec[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/intrpt_ctrl_irq_sync.sv
// -----------------------------------------------------------------------------
// intrpt_ctrl_irq_sync
//   Multi-stage synchronizer for the asynchronous external interrupt line,
//   plus one extra flop for rising-edge detection.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     ext_irq   : asynchronous interrupt request
//     irq_s     : synchronized level (after SYNC_STAGES flops)
//     rise      : one-cycle pulse on a 0->1 transition of irq_s
// -----------------------------------------------------------------------------
module intrpt_ctrl_irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ext_irq,
   output logic irq_s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   irq_s_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         irq_s_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_irq};
         irq_s_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign irq_s = sync_q[SYNC_STAGES-1];
   assign rise  = irq_s & ~irq_s_d;

endmodule

// File: rtl/intrpt_ctrl.sv
// -----------------------------------------------------------------------------
// intrpt_ctrl
//   Machine-mode interrupt sequencer. Synchronizes ext_irq, holds it pending,
//   takes a trap at an instruction boundary when MIE allows it, and handles
//   mret (return to mepc, restore MIE from the internal MPIE bit).
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     ext_irq           : asynchronous interrupt request
//     instr_done        : instruction-boundary strobe from the control FSM
//     mret              : current instruction is mret (qualified by instr_done)
//     csr_mie           : MIE from the CSR file
//     csr_mtvec         : trap vector
//     csr_mepc          : return address
//     intrpt_taken      : trap-entry pulse to the CSR file
//     pc_redirect       : PC mux selects pc_target this cycle
//     pc_target         : redirect address
//     mie_wr_en/data    : MIE write request (goes to CSR_MIE_ADDR)
//     in_handler        : high while servicing a trap
//     state, pending    : observability of the sequencer state and pending bit
//
//   Handshake note: there is no valid/ready pair here. Every pulse output is a
//   combinational, single-cycle strobe qualified by instr_done; consumers must
//   act on it in the same cycle, and it is never held or retried.
// -----------------------------------------------------------------------------
module intrpt_ctrl
   import intrpt_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_TRIG   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ext_irq,
   input  logic        instr_done,
   input  logic        mret,
   input  logic        csr_mie,
   input  logic [31:0] csr_mtvec,
   input  logic [31:0] csr_mepc,
   output logic        intrpt_taken,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic        mie_wr_en,
   output logic        mie_wr_data,
   output logic        in_handler,
   output logic [1:0]  state,
   output logic        pending
);

   logic   irq_s;
   logic   rise;
   logic   pending_q;
   logic   mpie_q, mpie_d;
   state_t state_q, state_d;

   intrpt_ctrl_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .ext_irq (ext_irq),
      .irq_s   (irq_s),
      .rise    (rise)
   );

   // Edge latch: a rise in the same cycle as the take wins, so a fresh edge
   // arriving while the previous one is being taken is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= rise | (pending_q & ~intrpt_taken);
      end
   end

   assign pending = EDGE_TRIG ? pending_q : irq_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mpie_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mpie_q  <= mpie_d;
      end
   end

   // Outputs are forced low during reset so a trap in flight is abandoned
   // without emitting a stray redirect.
   always_comb begin
      state_d      = state_q;
      mpie_d       = mpie_q;
      intrpt_taken = 1'b0;
      pc_redirect  = 1'b0;
      pc_target    = 32'h0;
      mie_wr_en    = 1'b0;
      mie_wr_data  = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               // mret outranks a pending interrupt in the same boundary.
               if (instr_done && mret) begin
                  pc_redirect = 1'b1;
                  pc_target   = csr_mepc;
                  mie_wr_en   = 1'b1;
                  mie_wr_data = mpie_q;
                  mpie_d      = 1'b1;
               end else if (instr_done && pending && csr_mie) begin
                  intrpt_taken = 1'b1;
                  pc_redirect  = 1'b1;
                  pc_target    = align_mtvec(csr_mtvec);
                  mpie_d       = csr_mie;
                  state_d      = HANDLER;
               end
            end
            HANDLER: begin
               // No nesting: new requests only accumulate in pending.
               if (instr_done && mret) begin
                  pc_redirect = 1'b1;
                  pc_target   = csr_mepc;
                  mie_wr_en   = 1'b1;
                  mie_wr_data = mpie_q;
                  mpie_d      = 1'b1;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign in_handler = !rst && (state_q == HANDLER);
   assign state      = state_q;

endmodule

// File: tb/tb_intrpt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intrpt_ctrl
//   Directed bench for intrpt_ctrl (SYNC_STAGES=2, EDGE_TRIG=1). Inputs change
//   1 time unit after each rising edge; outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_intrpt_ctrl;

   logic        clk;
   logic        rst;
   logic        ext_irq;
   logic        instr_done;
   logic        mret;
   logic        csr_mie;
   logic [31:0] csr_mtvec;
   logic [31:0] csr_mepc;
   logic        intrpt_taken;
   logic        pc_redirect;
   logic [31:0] pc_target;
   logic        mie_wr_en;
   logic        mie_wr_data;
   logic        in_handler;
   logic [1:0]  state;
   logic        pending;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   intrpt_ctrl #(
      .SYNC_STAGES (2),
      .EDGE_TRIG   (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ext_irq      (ext_irq),
      .instr_done   (instr_done),
      .mret         (mret),
      .csr_mie      (csr_mie),
      .csr_mtvec    (csr_mtvec),
      .csr_mepc     (csr_mepc),
      .intrpt_taken (intrpt_taken),
      .pc_redirect  (pc_redirect),
      .pc_target    (pc_target),
      .mie_wr_en    (mie_wr_en),
      .mie_wr_data  (mie_wr_data),
      .in_handler   (in_handler),
      .state        (state),
      .pending      (pending)
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one clock; return 1 unit after the edge, ready for new inputs.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   // Drop ext_irq long enough to clear the sync chain, raise it, and wait
   // until the edge is latched (3 edges). Counts any trap taken meanwhile.
   task automatic raise_irq(output int takes);
      takes = 0;
      ext_irq = 1'b0;
      repeat (3) begin
         cyc();
         if (intrpt_taken) takes++;
      end
      ext_irq = 1'b1;
      repeat (3) begin
         cyc();
         if (intrpt_taken) takes++;
      end
   endtask

   // mret at a boundary from HANDLER; checks the return redirect.
   task automatic do_return(input string tag, input logic exp_mie);
      mret = 1'b1;
      instr_done = 1'b1;
      settle();
      chk({tag, "_redir"}, pc_redirect, 1);
      chk({tag, "_target"}, pc_target, 32'h40);
      chk({tag, "_mie_wr_en"}, mie_wr_en, 1);
      chk({tag, "_mie_wr_data"}, mie_wr_data, exp_mie);
      chk({tag, "_no_take"}, intrpt_taken, 0);
      cyc();
      mret = 1'b0;
      instr_done = 1'b0;
      settle();
      chk({tag, "_state_idle"}, state, 0);
      chk({tag, "_not_in_handler"}, in_handler, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int takes;

      rst        = 1'b1;
      ext_irq    = 1'b1;
      instr_done = 1'b1;
      mret       = 1'b1;
      csr_mie    = 1'b1;
      csr_mtvec  = 32'h0000_0103;
      csr_mepc   = 32'h0000_0040;

      // Reset: two edges with every input trying to provoke an output.
      cyc();
      cyc();
      settle();
      chk("rst_taken", intrpt_taken, 0);
      chk("rst_redirect", pc_redirect, 0);
      chk("rst_target", pc_target, 0);
      chk("rst_mie_wr_en", mie_wr_en, 0);
      chk("rst_mie_wr_data", mie_wr_data, 0);
      chk("rst_in_handler", in_handler, 0);
      chk("rst_state", state, 0);
      chk("rst_pending", pending, 0);

      rst        = 1'b0;
      mret       = 1'b0;
      instr_done = 1'b0;
      cyc();
      chk("rel_pending_e1", pending, 0);
      cyc();
      chk("rel_pending_e2", pending, 0);
      cyc();
      chk("rel_pending_e3", pending, 1);

      // Simultaneous mret and pending interrupt in IDLE: mret wins; MPIE is
      // still 0 from reset so the restored MIE is 0.
      mret = 1'b1;
      instr_done = 1'b1;
      settle();
      chk("sim_redirect", pc_redirect, 1);
      chk("sim_target", pc_target, 32'h40);
      chk("sim_mie_wr_en", mie_wr_en, 1);
      chk("sim_mie_wr_data", mie_wr_data, 0);
      chk("sim_no_take", intrpt_taken, 0);
      cyc();
      mret = 1'b0;
      settle();
      chk("sim_next_take", intrpt_taken, 1);
      chk("sim_next_target", pc_target, 32'h100);
      chk("sim_next_no_mie_wr", mie_wr_en, 0);
      cyc();
      instr_done = 1'b0;
      settle();
      chk("sim_in_handler", in_handler, 1);
      chk("sim_state_handler", state, 1);
      chk("sim_pending_clr", pending, 0);
      chk("sim_pulse_gone", pc_redirect, 0);
      do_return("ret1", 1'b1);

      // Basic take: fresh edge, instr_done every cycle; the take appears
      // only once the edge has been latched (third edge).
      ext_irq = 1'b0;
      repeat (3) cyc();
      ext_irq = 1'b1;
      instr_done = 1'b1;
      cyc();
      chk("basic_e1_no_take", intrpt_taken, 0);
      cyc();
      chk("basic_e2_no_take", intrpt_taken, 0);
      cyc();
      chk("basic_e3_take", intrpt_taken, 1);
      chk("basic_redirect", pc_redirect, 1);
      chk("basic_target", pc_target, 32'h100);
      chk("basic_in_handler_lo", in_handler, 0);
      cyc();
      instr_done = 1'b0;
      settle();
      chk("basic_take_once", intrpt_taken, 0);
      chk("basic_in_handler", in_handler, 1);
      do_return("ret2", 1'b1);

      // Masked: one-cycle pulse with MIE=0, boundaries every cycle.
      csr_mie = 1'b0;
      ext_irq = 1'b0;
      repeat (3) cyc();
      ext_irq = 1'b1;
      cyc();
      ext_irq = 1'b0;
      instr_done = 1'b1;
      takes = 0;
      repeat (10) begin
         cyc();
         if (intrpt_taken) takes++;
      end
      chk("mask_no_take", takes, 0);
      chk("mask_pending_held", pending, 1);
      csr_mie = 1'b1;
      settle();
      chk("mask_unmask_take", intrpt_taken, 1);
      chk("mask_unmask_target", pc_target, 32'h100);
      cyc();
      instr_done = 1'b0;
      settle();
      chk("mask_in_handler", in_handler, 1);
      do_return("ret3", 1'b1);

      // Enter HANDLER again, then a second edge while inside it.
      raise_irq(takes);
      instr_done = 1'b1;
      settle();
      chk("hnd_enter_take", intrpt_taken, 1);
      cyc();
      raise_irq(takes);
      chk("hnd_no_nesting", takes, 0);
      chk("hnd_pending", pending, 1);
      chk("hnd_still_in", in_handler, 1);
      mret = 1'b1;
      settle();
      chk("hnd_mret_redirect", pc_redirect, 1);
      chk("hnd_mret_no_take", intrpt_taken, 0);
      chk("hnd_mret_target", pc_target, 32'h40);
      cyc();
      mret = 1'b0;
      settle();
      chk("hnd_after_ret_take", intrpt_taken, 1);
      chk("hnd_after_ret_target", pc_target, 32'h100);
      cyc();
      instr_done = 1'b0;
      settle();
      chk("hnd_reenter", in_handler, 1);

      // Reset mid-handler with an edge pending.
      raise_irq(takes);
      chk("mid_pending_before", pending, 1);
      rst = 1'b1;
      cyc();
      chk("mid_in_handler", in_handler, 0);
      chk("mid_pending", pending, 0);
      chk("mid_state", state, 0);
      rst = 1'b0;
      ext_irq = 1'b0;
      repeat (2) cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #20000;
      n_errors++;
      $display("FAIL timeout: got no finish, expected finish before 20000");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
